// File: rtl/osd_pkg.sv
// osd_pkg: shared OSD types, glyph geometry, default RAM bases and window compare
package osd_pkg;
  typedef enum logic [1:0] {IDLE, CHR, FNT, LOAD} fetch_state_t;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam logic [10:0] DEF_TEXT_BASE = 11'h000;
  localparam logic [10:0] DEF_FONT_BASE = 11'h400;
  function automatic logic win_cmp(input logic [10:0] pos, input logic [10:0] lo, input logic [11:0] span);
    return ({1'b0, pos} >= {1'b0, lo}) && ({1'b0, pos} < {1'b0, lo} + span);
  endfunction
endpackage

// File: rtl/osd_cell_fetch.sv
// osd_cell_fetch: three-clock char/font fetch FSM driving RAM port B into the next-row buffer
module osd_cell_fetch
  import osd_pkg::*;
#(
  parameter logic [10:0] FONT_BASE = DEF_FONT_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [10:0] text_adr,
  input  logic [2:0]  grow,
  output logic [10:0] ram_adr,
  output logic        ram_ce,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  nxt_row,
  output logic        nxt_inv,
  output logic        fetch_err
);
  fetch_state_t state, state_nx;
  logic [10:0] adr_q;
  logic code_inv;
  // state register; reset aborts any fetch in flight
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state and RAM port; font address uses the char code straight off the RAM
  always_comb begin
    state_nx = state == IDLE ? (req ? CHR : IDLE) : state == CHR ? FNT : state == FNT ? LOAD : IDLE;
    ram_ce = state == CHR || state == FNT;
    ram_adr = state == CHR ? adr_q : state == FNT ? FONT_BASE + {1'b0, ram_dout[6:0], grow} : 11'd0;
  end
  // request capture, code latch, next-row load and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q <= '0;
      code_inv <= 1'b0;
      nxt_row <= '0;
      nxt_inv <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      if (req && state == IDLE) adr_q <= text_adr;
      if (req && state != IDLE) fetch_err <= 1'b1;
      if (state == FNT) code_inv <= ram_dout[7];
      if (state == LOAD) begin
        nxt_row <= ram_dout;
        nxt_inv <= code_inv;
      end
    end
  end
endmodule

// File: rtl/osd_menu_renderer.sv
// osd_menu_renderer: scanline text overlay from menu RAM; OSD_BORDER_EN adds a 1-pixel window frame
module osd_menu_renderer
  import osd_pkg::*;
#(
  parameter int          COLS      = 32,
  parameter int          ROWS      = 16,
  parameter int          X0        = 64,
  parameter int          Y0        = 48,
  parameter logic [10:0] TEXT_BASE = DEF_TEXT_BASE,
  parameter logic [10:0] FONT_BASE = DEF_FONT_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        osd_en,
  input  logic        pix_ce,
  input  logic        line_start,
  input  logic [10:0] h_pos,
  input  logic [10:0] v_pos,
  output logic [10:0] ram_adr,
  output logic        ram_ce,
  input  logic [7:0]  ram_dout,
  output logic        osd_active,
  output logic        osd_pix,
  output logic        fetch_err
);
  localparam logic [11:0] WIN_W = 12'(GLYPH_W * COLS);
  localparam logic [11:0] WIN_H = 12'(GLYPH_H * ROWS);
  logic [10:0] wx, wy, text_adr;
  logic [7:0] col, fcol, nxt_row, cur_row;
  logic [2:0] sub;
  logic line_in, h_in, in_win, col_ok, req, xfer, frame, active_nx, pix_nx, nxt_inv, cur_inv;
  assign wx = h_pos - 11'(X0);
  assign wy = v_pos - 11'(Y0);
  assign col = wx[10:3];
  assign sub = wx[2:0];
  assign line_in = win_cmp(v_pos, 11'(Y0), WIN_H);
  assign h_in = win_cmp(h_pos, 11'(X0), WIN_W);
  assign in_win = line_in & h_in;
  assign col_ok = col < 8'(COLS - 1);
  assign req = (line_start & line_in) | (pix_ce & in_win & sub == 3'd0 & col_ok);
  assign fcol = line_start ? 8'd0 : col + 8'd1;
  assign text_adr = TEXT_BASE + {3'b0, wy[10:3]} * 11'(COLS) + {3'b0, fcol};
  assign xfer = pix_ce & line_in & (h_pos == 11'(X0 - 1) | (h_in & sub == 3'd7 & col_ok));
`ifdef OSD_BORDER_EN
  assign frame = (win_cmp(v_pos, 11'(Y0 - 1), WIN_H + 12'd2) & (h_pos == 11'(X0 - 1) | h_pos == 11'(X0 + GLYPH_W * COLS)))
               | (win_cmp(h_pos, 11'(X0 - 1), WIN_W + 12'd2) & (v_pos == 11'(Y0 - 1) | v_pos == 11'(Y0 + GLYPH_H * ROWS)));
`else
  assign frame = 1'b0;
`endif
  assign active_nx = osd_en & (in_win | frame);
  assign pix_nx = osd_en & (frame | (in_win & (cur_row[sub] ^ cur_inv)));
  osd_cell_fetch #(.FONT_BASE(FONT_BASE)) u_fetch (
    .clk(clk),
    .reset(reset),
    .req(req),
    .text_adr(text_adr),
    .grow(wy[2:0]),
    .ram_adr(ram_adr),
    .ram_ce(ram_ce),
    .ram_dout(ram_dout),
    .nxt_row(nxt_row),
    .nxt_inv(nxt_inv),
    .fetch_err(fetch_err)
  );
  // current-row transfer and pixel output registers, updated one clock after each strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_row <= '0;
      cur_inv <= 1'b0;
      osd_active <= 1'b0;
      osd_pix <= 1'b0;
    end else begin
      if (xfer) begin
        cur_row <= nxt_row;
        cur_inv <= nxt_inv;
      end
      if (pix_ce) begin
        osd_active <= active_nx;
        osd_pix <= pix_nx;
      end
    end
  end
endmodule
